mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM pipeline register outputs (PC, zero, ALU result, store data, write address, control bits).
- Performs data-memory loads and stores over a req/ack handshake with timeout, resolves branch and jump-register redirects, and registers the MEM/WB pipeline outputs.
- Stalls upstream while a memory access is outstanding.

Parameters:
TIMEOUT, 16, cycles in BUSY without dmem_ack before the access is aborted (>=1)
CNT_W, 5, width of the wait counter; must hold TIMEOUT

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  EX/MEM slot holds a real instruction
reg_write_in  input  1  instruction writes the register file
mem_read_in  input  1  load word
mem_write_in  input  1  store word
mem_to_reg_in  input  1  WB selects load data
branch_in  input  1  conditional branch (beq)
jump_reg_in  input  1  jr
zero_in  input  1  ALU zero flag
pc_in  input  32  branch target PC from EX
result_in  input  32  ALU result / memory address / jr target
data2_in  input  32  store data
write_addr_in  input  5  destination register
dmem_req  output  1  memory request
dmem_we  output  1  1 = store
dmem_addr  output  32  word address (= result_in)
dmem_wdata  output  32  = data2_in
dmem_rdata  input  32  load data, valid with dmem_ack
dmem_ack  input  1  access complete this cycle
stall  output  1  hold IF/ID/EX and the EX/MEM register
pc_src  output  1  redirect fetch this cycle
pc_target  output  32  redirect address
valid_out  output  1  MEM/WB slot valid
reg_write_out  output  1  MEM/WB reg_write
mem_to_reg_out  output  1  MEM/WB mem_to_reg
read_data_out  output  32  MEM/WB load data
result_out  output  32  MEM/WB ALU result
write_addr_out  output  5  MEM/WB destination
misalign_err  output  1  1-cycle pulse, misaligned access dropped
bus_err  output  1  1-cycle pulse, access timed out

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0.
  - All registered outputs are 0.
  - dmem_req, stall and pc_src are forced to 0 combinationally while rst_n=0, including mid-access. Any in-flight access is abandoned.
- Definitions:
  - mem_op = valid_in & (mem_read_in | mem_write_in).
  - aligned = (result_in[1:0]==0).
  - start = IDLE & mem_op & aligned.
  - timeout_hit = BUSY & (cnt==TIMEOUT).
- Combinational outputs:
  - dmem_req = start | (BUSY & ~timeout_hit).
  - dmem_we = mem_write_in.
  - dmem_addr = result_in; dmem_wdata = data2_in.
  - stall = dmem_req & ~dmem_ack.
- FSM states IDLE and BUSY:
  - IDLE, start & dmem_ack: zero-wait access; completes this cycle, stays IDLE, no stall.
  - IDLE, start & ~dmem_ack: go to BUSY, cnt<=1.
  - BUSY, dmem_ack: complete, go to IDLE, cnt<=0.
  - BUSY, timeout_hit: abort, go to IDLE. bus_err<=1, MEM/WB gets a bubble, stall=0 so the instruction is dropped. An ack in this cycle is ignored.
  - BUSY, otherwise: cnt<=cnt+1.
- Upstream holds all *_in stable while stall=1.
- MEM/WB update every cycle:
  - Completion cycle, or a non-memory instruction with stall=0: valid_out<=valid_in, reg_write_out<=reg_write_in & valid_in, mem_to_reg_out<=mem_to_reg_in, result_out<=result_in, write_addr_out<=write_addr_in, read_data_out<=dmem_rdata on load completion, else unchanged.
  - Stall cycles, aborts and misaligned ops: bubble (valid_out<=0, reg_write_out<=0). Data fields are don't-care but held.
- Misaligned mem_op in IDLE:
  - No request is issued, no stall.
  - misalign_err<=1 for one cycle; bubble into MEM/WB (store suppressed, load writes nothing).
- Redirect:
  - pc_src = valid_in & ~stall & ((branch_in & zero_in) | jump_reg_in).
  - pc_target = jump_reg_in ? result_in : pc_in.
  - jump_reg_in has priority when both are set.
- Latency: every instruction reaches MEM/WB on the clock edge ending its completion cycle. A load with N wait cycles reaches MEM/WB N cycles later than a non-memory instruction.
- misalign_err and bus_err are registered pulses, cleared the following cycle.

Test Plan:
- Reset mid-access: assert rst_n=0 while in BUSY with cnt=3 -> dmem_req, stall and all outputs 0 immediately; after release, state is IDLE and the next access starts cleanly.
- Zero-wait load: result_in=0x100, mem_read_in=1, dmem_ack=1 same cycle, dmem_rdata=0xDEADBEEF -> stall never asserted; next edge gives read_data_out=0xDEADBEEF, write_addr_out=write_addr_in, valid_out=1.
- 3-wait store: mem_write_in=1, addr 0x40, data 0x1234, ack on the 4th cycle -> dmem_req high for 4 cycles with stall=1 on the first 3, dmem_we=1 and address/data stable throughout; bubbles in MEM/WB until completion, then valid_out=1 and reg_write_out=0.
- Timeout: TIMEOUT=4, load never acked -> dmem_req for 4 cycles, dropped on the 5th with stall=0; bus_err pulses once, valid_out=0, reg_write_out=0.
- Misaligned: load from result_in=0x102 -> no dmem_req, misalign_err pulses, reg_write_out=0.
- Redirect: beq with zero_in=1, pc_in=0x80 -> pc_src=1, pc_target=0x80. jr with result_in=0x200 -> pc_target=0x200. beq with zero_in=0 -> pc_src=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of a 5-stage MIPS pipeline.
// Drives a req/ack data-memory port with a wait-cycle timeout, resolves
// branch / jr redirects and registers the MEM/WB pipeline outputs.
//
// Handshake: dmem_req is held high until the access completes (dmem_req &
// dmem_ack in the same cycle) or times out. dmem_ack is sampled only while
// dmem_req is high, and the request attributes (dmem_we/addr/wdata) stay
// stable because upstream holds all *_in inputs while stall is high.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        branch_in,
    input  logic        jump_reg_in,
    input  logic        zero_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] result_in,
    input  logic [31:0] data2_in,
    input  logic [4:0]  write_addr_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        valid_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic [31:0] read_data_out,
    output logic [31:0] result_out,
    output logic [4:0]  write_addr_out,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        valid_q, valid_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  write_addr_q, write_addr_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic mem_op;
    logic aligned;
    logic is_idle;
    logic is_busy;
    logic start;
    logic timeout_hit;
    logic req_raw;
    logic complete;

    assign mem_op      = valid_in & (mem_read_in | mem_write_in);
    assign aligned     = (result_in[1:0] == 2'b00);
    assign is_idle     = (state_q == IDLE);
    assign is_busy     = (state_q == BUSY);
    assign start       = is_idle & mem_op & aligned;
    assign timeout_hit = is_busy & (cnt_q == TIMEOUT_C);
    assign req_raw     = start | (is_busy & ~timeout_hit);

    // Request, stall and redirect are gated by rst_n so a reset in the middle
    // of an access drops them immediately rather than on the next edge.
    assign dmem_req   = rst_n & req_raw;
    assign stall      = dmem_req & ~dmem_ack;
    assign complete   = dmem_req & dmem_ack;
    assign dmem_we    = mem_write_in;
    assign dmem_addr  = result_in;
    assign dmem_wdata = data2_in;

    // jr wins over a taken branch when both are flagged.
    assign pc_src    = rst_n & valid_in & ~stall & ((branch_in & zero_in) | jump_reg_in);
    assign pc_target = jump_reg_in ? result_in : pc_in;

    // Access FSM: IDLE issues, BUSY counts wait cycles until ack or timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start & ~dmem_ack) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(1);
                end
            end
            BUSY: begin
                // Timeout takes priority: an ack arriving on the abort cycle is ignored.
                if (timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB next value: pass the instruction through on completion or when
    // it needs no memory, otherwise insert a bubble and hold the data fields.
    always_comb begin
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = mem_to_reg_q;
        read_data_d  = read_data_q;
        result_d     = result_q;
        write_addr_d = write_addr_q;
        misalign_d   = is_idle & mem_op & ~aligned;
        bus_err_d    = timeout_hit;
        if (complete | (~mem_op & ~stall)) begin
            valid_d      = valid_in;
            reg_write_d  = reg_write_in & valid_in;
            mem_to_reg_d = mem_to_reg_in;
            result_d     = result_in;
            write_addr_d = write_addr_in;
            if (complete & mem_read_in) begin
                read_data_d = dmem_rdata;
            end
        end
    end

    // State and pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= '0;
            result_q     <= '0;
            write_addr_q <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            result_q     <= result_d;
            write_addr_q <= write_addr_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign valid_out      = valid_q;
    assign reg_write_out  = reg_write_q;
    assign mem_to_reg_out = mem_to_reg_q;
    assign read_data_out  = read_data_q;
    assign result_out     = result_q;
    assign write_addr_out = write_addr_q;
    assign misalign_err   = misalign_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed stimulus for mem_stage, with an
// expected-output queue filled by the driver and drained by a monitor.
module tb_mem_stage;

  localparam int TO = 4;
  localparam int EW = 74;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        br;
    logic        jr;
    logic        z;
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] d2;
    logic [4:0]  wa;
  } instr_t;

  logic        clk;
  logic        rst_n;
  logic        valid_in, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        branch_in, jump_reg_in, zero_in;
  logic [31:0] pc_in, result_in, data2_in;
  logic [4:0]  write_addr_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src;
  logic [31:0] pc_target;
  logic        valid_out, reg_write_out, mem_to_reg_out;
  logic [31:0] read_data_out, result_out;
  logic [4:0]  write_addr_out;
  logic        misalign_err, bus_err;

  // {valid, reg_write, mem_to_reg, misalign, bus_err, write_addr, result, read_data}
  logic [EW-1:0] exp_q[$];
  logic [31:0]   last_rd;
  int            total;
  int            bad;

  mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in),
    .jump_reg_in(jump_reg_in), .zero_in(zero_in),
    .pc_in(pc_in), .result_in(result_in), .data2_in(data2_in),
    .write_addr_in(write_addr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .valid_out(valid_out), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out), .read_data_out(read_data_out),
    .result_out(result_out), .write_addr_out(write_addr_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input instr_t i);
    valid_in      = i.v;
    reg_write_in  = i.rw;
    mem_read_in   = i.mr;
    mem_write_in  = i.mw;
    mem_to_reg_in = i.m2r;
    branch_in     = i.br;
    jump_reg_in   = i.jr;
    zero_in       = i.z;
    pc_in         = i.pc;
    result_in     = i.res;
    data2_in      = i.d2;
    write_addr_in = i.wa;
  endtask

  task automatic push(input logic v, input logic rw, input logic m2r, input logic mis,
                      input logic be, input instr_t i);
    exp_q.push_back({v, rw, m2r, mis, be, i.wa, i.res, last_rd});
  endtask

  // Holds one instruction in the EX/MEM slot for as long as the memory takes.
  // The memory acks after 'waits' wait cycles; waits >= TO means it never
  // acks before the timeout (waits == TO acks exactly on the abort cycle).
  task automatic issue(input instr_t i, input int waits, input logic [31:0] rdata);
    logic mem_op, aligned, acc, er, es, ep;
    int   cycles;
    mem_op  = i.v & (i.mr | i.mw);
    aligned = (i.res[1:0] == 2'b00);
    acc     = mem_op & aligned;
    if (!acc)            cycles = 1;
    else if (waits < TO) cycles = waits + 1;
    else                 cycles = TO + 1;

    if (!mem_op) begin
      if (i.v) push(1'b1, i.rw, i.m2r, 1'b0, 1'b0, i);
    end else if (!aligned) begin
      push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, i);
    end else if (waits < TO) begin
      if (i.mr) last_rd = rdata;
      push(1'b1, i.rw, i.m2r, 1'b0, 1'b0, i);
    end else begin
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, i);
    end

    apply(i);
    for (int c = 0; c < cycles; c++) begin
      if (acc) dmem_ack = (c == waits);
      else     dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = (c == waits) ? rdata : $urandom;
      er = acc & ((waits < TO) ? 1'b1 : (c < TO));
      es = acc & ((waits < TO) ? (c < waits) : (c < TO));
      ep = i.v & ~es & ((i.br & i.z) | i.jr);
      @(negedge clk);
      chk("dmem_req", dmem_req, er);
      chk("stall", stall, es);
      chk("pc_src", pc_src, ep);
      if (er) begin
        chk("dmem_we", dmem_we, i.mw);
        chk("dmem_addr", dmem_addr, i.res);
        chk("dmem_wdata", dmem_wdata, i.d2);
      end
      if (ep) chk("pc_target", pc_target, i.jr ? i.res : i.pc);
      @(posedge clk);
      #1;
    end
    dmem_ack = 1'b0;
  endtask

  function automatic instr_t idle_instr();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t      i;
    int          kind;
    logic [31:0] r;
    logic [1:0]  lo;
    i      = '0;
    kind   = $urandom_range(0, 2);
    i.v    = ($urandom_range(0, 9) != 0);
    i.rw   = 1'($urandom_range(0, 1));
    i.m2r  = 1'($urandom_range(0, 1));
    i.pc   = $urandom;
    i.d2   = $urandom;
    i.wa   = 5'($urandom_range(0, 31));
    r      = $urandom;
    lo     = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    i.res  = {r[31:2], lo};
    if (kind == 1) i.mr = 1'b1;
    if (kind == 2) i.mw = 1'b1;
    if (kind == 0) begin
      i.br = 1'($urandom_range(0, 1));
      i.jr = 1'($urandom_range(0, 1));
      i.z  = 1'($urandom_range(0, 1));
    end
    return i;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (valid_out | misalign_err | bus_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {valid_out, misalign_err, bus_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("valid_out", valid_out, e[73]);
          chk("reg_write_out", reg_write_out, e[72]);
          chk("misalign_err", misalign_err, e[70]);
          chk("bus_err", bus_err, e[69]);
          if (e[73]) begin
            chk("mem_to_reg_out", mem_to_reg_out, e[71]);
            chk("write_addr_out", write_addr_out, e[68:64]);
            chk("result_out", result_out, e[63:32]);
            chk("read_data_out", read_data_out, e[31:0]);
          end
        end
      end else begin
        chk("bubble_reg_write", reg_write_out, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t i;
    total      = 0;
    bad        = 0;
    last_rd    = '0;
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    apply(idle_instr());

    #12;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_reg_write_out", reg_write_out, 0);
    chk("rst_read_data_out", read_data_out, 0);
    chk("rst_result_out", result_out, 0);
    chk("rst_write_addr_out", write_addr_out, 0);
    chk("rst_errs", {misalign_err, bus_err}, 0);
    chk("rst_dmem_req", dmem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // zero-wait load
    i = '0; i.v = 1; i.rw = 1; i.mr = 1; i.m2r = 1; i.res = 32'h100; i.wa = 5'd9;
    issue(i, 0, 32'hDEADBEEF);
    // 3-wait store
    i = '0; i.v = 1; i.mw = 1; i.res = 32'h40; i.d2 = 32'h1234; i.wa = 5'd3;
    issue(i, 3, 32'h0);
    // load never acked -> timeout
    i = '0; i.v = 1; i.rw = 1; i.mr = 1; i.m2r = 1; i.res = 32'h80; i.wa = 5'd4;
    issue(i, 99, 32'h5555AAAA);
    // ack arriving on the abort cycle is ignored
    i = '0; i.v = 1; i.rw = 1; i.mr = 1; i.res = 32'h84; i.wa = 5'd5;
    issue(i, TO, 32'h77777777);
    // longest successful wait
    i = '0; i.v = 1; i.rw = 1; i.mr = 1; i.res = 32'h88; i.wa = 5'd6;
    issue(i, TO - 1, 32'hCAFEF00D);
    // misaligned load
    i = '0; i.v = 1; i.rw = 1; i.mr = 1; i.res = 32'h102; i.wa = 5'd7;
    issue(i, 0, 32'h0);
    // redirects
    i = '0; i.v = 1; i.br = 1; i.z = 1; i.pc = 32'h80; i.res = 32'h11;
    issue(i, 0, 32'h0);
    i = '0; i.v = 1; i.jr = 1; i.pc = 32'h90; i.res = 32'h200;
    issue(i, 0, 32'h0);
    i = '0; i.v = 1; i.br = 1; i.jr = 1; i.z = 1; i.pc = 32'h90; i.res = 32'h300;
    issue(i, 0, 32'h0);
    i = '0; i.v = 1; i.br = 1; i.z = 0; i.pc = 32'h80;
    issue(i, 0, 32'h0);

    // reset in the middle of an access (cnt reaches 3)
    i = '0; i.v = 1; i.rw = 1; i.mr = 1; i.jr = 1; i.res = 32'h300; i.wa = 5'd8;
    apply(i);
    dmem_ack = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_dmem_req", dmem_req, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_pc_src", pc_src, 0);
    chk("rstmid_valid_out", valid_out, 0);
    chk("rstmid_read_data_out", read_data_out, 0);
    chk("rstmid_result_out", result_out, 0);
    last_rd = '0;
    @(negedge clk);
    apply(idle_instr());
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    i = '0; i.v = 1; i.rw = 1; i.mr = 1; i.m2r = 1; i.res = 32'h104; i.wa = 5'd10;
    issue(i, 1, 32'h13572468);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      issue(rand_instr(), $urandom_range(0, 6), $urandom);
    end

    apply(idle_instr());
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
